// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch controller with prefetch queue, redirect, halt; IFETCH_MISALIGN_CHK_EN enables misaligned-redirect fault
module ifetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          push, pop, full, bad_target;
  logic [31:0]   target;
`ifdef IFETCH_MISALIGN_CHK_EN
  assign target     = redirect_pc;
  assign bad_target = |redirect_pc[1:0];
  assign fault      = state == FAULT;
`else
  assign target     = redirect_pc & ~32'h3;
  assign bad_target = 1'b0;
  assign fault      = 1'b0;
`endif
  assign imem_addr = fetch_pc;
  assign out_valid = count != '0;
  assign out_instr = q_instr[head];
  assign out_pc    = q_pc[head];
  assign halted    = state == HALT;
  // queue handshake and next state; redirect overrides everything, halt_req blocks new fetches immediately
  always_comb begin
    full      = count == (AW+1)'(DEPTH);
    pop       = out_valid && out_ready && !redirect;
    push      = !redirect && state == RUN && !halt_req && (!full || pop);
    state_nxt = redirect ? (bad_target ? FAULT : RUN) :
                (state == RUN && halt_req) ? HALT :
                (state == HALT && !halt_req) ? RUN : state;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end
  // fetch pointer and prefetch queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= target;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        q_pc[tail]    <= fetch_pc;
        q_instr[tail] <= imem_instr;
        tail          <= tail + 1'b1;
        fetch_pc      <= fetch_pc + 32'd4;
      end
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed vector table, corner sequences and randomized run against a queue-based fetch model
module tb_ifetch_ctrl;
  localparam int DEPTH = 4;
`ifdef IFETCH_MISALIGN_CHK_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif
  logic        clk = 0, rst_n = 0;
  logic [31:0] imem_addr, imem_instr, redirect_pc = 0, out_instr, out_pc;
  logic        redirect = 0, halt_req = 0, out_valid, out_ready = 0, halted, fault;
  int          errors = 0, checks = 0;
  logic [31:0] mq[$];
  logic [31:0] m_fpc = 0;
  bit          m_halted = 0, m_fault = 0;
  typedef struct {
    logic        r;
    logic [31:0] rpc;
    logic        h;
    logic        rd;
    logic        ev;
    logic [31:0] epc;
    logic        ef;
  } vec_t;
  vec_t tv[22];

  ifetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction
  assign imem_instr = mem_word(imem_addr);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fpc = 32'h0;
    m_halted = 0;
    m_fault = 0;
  endtask

  task automatic check_model();
    chk("m_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("m_addr", imem_addr, m_fpc);
    chk("m_halted", {31'b0, halted}, {31'b0, m_halted});
    chk("m_fault", {31'b0, fault}, {31'b0, m_fault});
    if (mq.size() != 0) begin
      chk("m_pc", out_pc, mq[0]);
      chk("m_instr", out_instr, mem_word(mq[0]));
    end
  endtask

  task automatic model_step(input logic r, input logic [31:0] rpc, input logic h, input logic rd);
    if (r) begin
      mq.delete();
      m_fault  = F && rpc[1:0] != 2'b00;
      m_fpc    = F ? rpc : {rpc[31:2], 2'b00};
      m_halted = 0;
    end else begin
      if (mq.size() != 0 && rd) void'(mq.pop_front());
      if (!m_halted && !m_fault && !h && mq.size() < DEPTH) begin
        mq.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
      if (!m_fault) m_halted = h;
    end
  endtask

  task automatic cycle(input logic r, input logic [31:0] rpc, input logic h, input logic rd);
    check_model();
    redirect = r;
    redirect_pc = rpc;
    halt_req = h;
    out_ready = rd;
    @(posedge clk);
    model_step(r, rpc, h, rd);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
  endtask

  initial begin
    tv[0]  = '{0, 32'h0, 0, 1, 0, 32'h0, 0};
    tv[1]  = '{0, 32'h0, 0, 1, 1, 32'h0, 0};
    tv[2]  = '{0, 32'h0, 0, 1, 1, 32'h4, 0};
    tv[3]  = '{0, 32'h0, 0, 1, 1, 32'h8, 0};
    tv[4]  = '{0, 32'h0, 0, 1, 1, 32'hC, 0};
    tv[5]  = '{1, 32'hFFFF_FFFC, 0, 1, 1, 32'h10, 0};
    tv[6]  = '{0, 32'h0, 0, 1, 0, 32'h0, 0};
    tv[7]  = '{0, 32'h0, 0, 1, 1, 32'hFFFF_FFFC, 0};
    tv[8]  = '{0, 32'h0, 0, 1, 1, 32'h0, 0};
    tv[9]  = '{0, 32'h0, 0, 1, 1, 32'h4, 0};
    tv[10] = '{0, 32'h0, 0, 0, 1, 32'h8, 0};
    tv[11] = '{0, 32'h0, 0, 0, 1, 32'h8, 0};
    tv[12] = '{1, 32'h40, 0, 1, 1, 32'h8, 0};
    tv[13] = '{0, 32'h0, 0, 1, 0, 32'h0, 0};
    tv[14] = '{0, 32'h0, 0, 1, 1, 32'h40, 0};
    tv[15] = '{0, 32'h0, 0, 1, 1, 32'h44, 0};
    tv[16] = '{1, 32'h42, 0, 1, 1, 32'h48, 0};
    tv[17] = '{0, 32'h0, 0, 1, 0, 32'h0, F};
    tv[18] = '{0, 32'h0, 0, 1, !F, 32'h40, F};
    tv[19] = '{1, 32'h80, 0, 1, !F, 32'h44, F};
    tv[20] = '{0, 32'h0, 0, 1, 0, 32'h0, 0};
    tv[21] = '{0, 32'h0, 0, 1, 1, 32'h80, 0};

    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("tv%0d_valid", i), {31'b0, out_valid}, {31'b0, tv[i].ev});
      if (tv[i].ev) chk($sformatf("tv%0d_pc", i), out_pc, tv[i].epc);
      chk($sformatf("tv%0d_fault", i), {31'b0, fault}, {31'b0, tv[i].ef});
      cycle(tv[i].r, tv[i].rpc, tv[i].h, tv[i].rd);
    end

    #2 rst_n = 0;
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) cycle(0, 32'h0, 0, 0);
    chk("stall_addr", imem_addr, 32'h10);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_pc%0d", k), out_pc, 32'(4 * k));
      cycle(0, 32'h0, 0, 1);
    end
    for (int k = 0; k < 6; k++) begin
      if (k >= 1) chk($sformatf("halt_flag%0d", k), {31'b0, halted}, 32'd1);
      cycle(0, 32'h0, 1, 1);
    end
    chk("halt_empty", {31'b0, out_valid}, 32'd0);
    chk("halt_addr", imem_addr, 32'h24);
    cycle(0, 32'h0, 0, 1);
    cycle(0, 32'h0, 0, 1);
    chk("resume_valid", {31'b0, out_valid}, 32'd1);
    chk("resume_pc", out_pc, 32'h24);

    begin
      logic h = 0;
      for (int n = 0; n < 500; n++) begin
        logic        r;
        logic [31:0] rpc;
        r = $urandom_range(0, 99) < 6;
        rpc = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
        if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
        if ($urandom_range(0, 9) == 0) h = ~h;
        cycle(r, rpc, h, $urandom_range(0, 9) < 7);
      end
    end
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
